// File: rtl/mem_xfer_sched_pkg.sv
// Shared types, sizes and small decode helpers for the memory-transfer scheduler.
package mem_xfer_sched_pkg;

  localparam int BUFF_TABLE_DEPTH = 10;
  localparam int ADDR_W           = 16;
  localparam int INSTR_W          = 32;
  localparam int NW_W             = 16;
  localparam int CNT_W            = $clog2(BUFF_TABLE_DEPTH + 1);
  localparam int PTR_W            = $clog2(BUFF_TABLE_DEPTH);

  typedef enum logic [4:0] {
    SETUP    = 5'd0,
    LD_MEM   = 5'd1,
    ST_MEM   = 5'd2,
    RD_BUF   = 5'd3,
    WR_BUF   = 5'd4,
    GEN_ADDR = 5'd5,
    COMPUTE  = 5'd6,
    LOOP     = 5'd7,
    BLK_END  = 5'd8
  } opcode_t;

  typedef enum logic [2:0] {
    IBUF = 3'b001,
    WBUF = 3'b010,
    OBUF = 3'b100
  } scratchpad_t;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [5:0]  op_spec;
    logic [4:0]  loop_id;
    logic [15:0] imm;
  } instr_fields_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } mem_sched_state_t;

  typedef struct packed {
    logic              we;
    logic [2:0]        spad;
    logic [2:0]        mem_width;
    logic [NW_W-1:0]   num_words;
    logic [ADDR_W-1:0] addr;
  } sched_entry_t;

  // A scratchpad selector is legal only when exactly one bit is set.
  function automatic logic spad_onehot(input logic [2:0] s);
    case (s)
      3'b001, 3'b010, 3'b100: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Map a one-hot scratchpad selector to its pointer-array index.
  function automatic logic [1:0] spad_idx(input logic [2:0] s);
    case (s)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_xfer_sched_if.sv
// Instruction-stream and memory-request bundle of the scheduler.
interface mem_xfer_sched_if;
  import mem_xfer_sched_pkg::*;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic               mem_req_we;
  logic [2:0]         mem_req_buf;
  logic [2:0]         mem_req_width;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_req_last;
  logic               blk_done;
  logic               instr_err;

  modport master (
    input  instr_valid, instr, mem_req_ready,
    output instr_ready, mem_req_valid, mem_req_we, mem_req_buf, mem_req_width,
           mem_req_addr, mem_req_last, blk_done, instr_err
  );

  modport slave (
    output instr_valid, instr, mem_req_ready,
    input  instr_ready, mem_req_valid, mem_req_we, mem_req_buf, mem_req_width,
           mem_req_addr, mem_req_last, blk_done, instr_err
  );

endinterface

// File: rtl/mem_xfer_sched_buf_table_fifo.sv
// Circular buffer table holding queued LD/ST transfers, with an occupancy counter.
module buf_table_fifo
  import mem_xfer_sched_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  sched_entry_t     push_data_i,
  input  logic             pop_i,
  output sched_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  sched_entry_t     mem_q [BUFF_TABLE_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUFF_TABLE_DEPTH - 1)) return '0;
    else return p + PTR_W'(1);
  endfunction

  assign full_o    = (count_q == CNT_W'(BUFF_TABLE_DEPTH));
  assign empty_o   = (count_q == CNT_W'(0));
  assign count_o   = count_q;
  assign head_o    = mem_q[head_q];
  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Next head/tail/count from this cycle's push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push_s) tail_d = ptr_inc(tail_q);
    else           tail_d = tail_q;
    if (do_pop_s)  head_d = ptr_inc(head_q);
    else           head_d = head_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless while the count says empty.
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_q[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/mem_xfer_sched.sv
// Memory-transfer scheduler: decodes SETUP/LD/ST/BLK_END, queues transfers and
// streams one word request per cycle to off-chip memory.
module mem_xfer_sched
  import mem_xfer_sched_pkg::*;
(
  input logic              CLK,
  input logic              nRST,
  mem_xfer_sched_if.master bus
);

  instr_fields_t          f_s;
  logic                   accept_s, spad_ok_s, hs_s;
  logic [1:0]             spad_idx_s;
  logic                   push_s, pop_s, blk_acc_s, blk_seen_s;
  sched_entry_t           push_entry_s, head_s;
  logic [CNT_W-1:0]       count_s, count_nxt_s;
  logic                   full_s, empty_s;
  logic [2:0][ADDR_W-1:0] ptr_q, ptr_d;
  mem_sched_state_t       state_q, state_d;
  logic                   valid_q, valid_d, we_q, we_d, last_q, last_d;
  logic                   ready_q, ready_d, done_q, done_d, err_q, err_d, pend_q, pend_d;
  logic [2:0]             spad_q, spad_d, width_q, width_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [NW_W-1:0]        rem_q, rem_d;
  logic                   unused_loop_id_s;

  assign f_s              = instr_fields_t'(bus.instr);
  assign unused_loop_id_s = ^f_s.loop_id;
  assign accept_s         = bus.instr_valid && ready_q;
  assign spad_ok_s        = spad_onehot(f_s.op_spec[2:0]);
  assign spad_idx_s       = spad_idx(f_s.op_spec[2:0]);
  assign hs_s             = valid_q && bus.mem_req_ready;
  assign blk_seen_s       = pend_q || blk_acc_s;

  buf_table_fifo u_table (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .count_o     (count_s),
    .full_o      (full_s),
    .empty_o     (empty_s)
  );

  // Decode the accepted instruction: pointer updates, table push, error and BLK_END.
  always_comb begin
    ptr_d        = ptr_q;
    push_s       = 1'b0;
    push_entry_s = '0;
    err_d        = 1'b0;
    blk_acc_s    = 1'b0;
    if (accept_s) begin
      case (f_s.opcode)
        SETUP: begin
          if (spad_ok_s) ptr_d[spad_idx_s] = ADDR_W'(f_s.imm);
          else           err_d = 1'b1;
        end
        LD_MEM, ST_MEM: begin
          if (!spad_ok_s) begin
            err_d = 1'b1;
          end else if (f_s.imm != 16'd0) begin
            push_s                 = 1'b1;
            push_entry_s.we        = (f_s.opcode == ST_MEM);
            push_entry_s.spad      = f_s.op_spec[2:0];
            push_entry_s.mem_width = f_s.op_spec[5:3];
            push_entry_s.num_words = f_s.imm;
            // Address is frozen now so later SETUPs never touch queued work.
            push_entry_s.addr      = ptr_q[spad_idx_s];
            ptr_d[spad_idx_s]      = ptr_q[spad_idx_s] + ADDR_W'(f_s.imm);
          end else begin
            push_s = 1'b0;
          end
        end
        BLK_END: blk_acc_s = 1'b1;
        default: blk_acc_s = 1'b0;
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  // Scratchpad address pointers.
  always_ff @(posedge CLK) begin
    if (!nRST) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and table pop; back-to-back pops on the last word avoid bubbles.
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_d = ISSUE;
        end else if (blk_seen_s) begin
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (hs_s && (rem_q == NW_W'(1))) begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_d = ISSUE;
          end else if (blk_seen_s) begin
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and working registers (next values, all registered below).
  always_comb begin
    addr_d  = addr_q;
    rem_d   = rem_q;
    we_d    = we_q;
    spad_d  = spad_q;
    width_d = width_q;
    if (pop_s) begin
      addr_d  = head_s.addr;
      rem_d   = head_s.num_words;
      we_d    = head_s.we;
      spad_d  = head_s.spad;
      width_d = head_s.mem_width;
    end else if (hs_s) begin
      addr_d = addr_q + ADDR_W'(1);
      rem_d  = rem_q - NW_W'(1);
    end else begin
      addr_d = addr_q;
    end
    valid_d = (state_d == ISSUE);
    last_d  = (rem_d == NW_W'(1));
    done_d  = (state_q == DRAIN) && (state_d == IDLE);
    if (done_d)         pend_d = 1'b0;
    else if (blk_acc_s) pend_d = 1'b1;
    else                pend_d = pend_q;
    count_nxt_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    ready_d     = (count_nxt_s != CNT_W'(BUFF_TABLE_DEPTH)) && !pend_d && (state_d != DRAIN);
  end

  // Output and working registers.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      spad_q  <= 3'b000;
      width_q <= 3'b000;
      addr_q  <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      spad_q  <= spad_d;
      width_q <= width_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.instr_ready   = ready_q;
  assign bus.mem_req_valid = valid_q;
  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_buf   = spad_q;
  assign bus.mem_req_width = width_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_last  = last_q;
  assign bus.blk_done      = done_q;
  assign bus.instr_err     = err_q;

endmodule

// File: tb/tb_mem_xfer_sched.sv
// Directed table-driven bench for mem_xfer_sched plus multi-cycle corner sequences.
module tb_mem_xfer_sched;
  import mem_xfer_sched_pkg::*;

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic [3:0]  ctrl;   // {mem_req_valid, instr_ready, instr_err, blk_done}
    logic [23:0] data;   // {we, buf, width, addr, last}, checked only when valid
  } vec_t;

  localparam logic [3:0] C_IDLE = 4'b0100;
  localparam logic [3:0] C_ISS  = 4'b1100;
  localparam logic [3:0] C_ERR  = 4'b0110;
  localparam logic [2:0] SP_I   = 3'b001;
  localparam logic [2:0] SP_W   = 3'b010;
  localparam logic [2:0] SP_O   = 3'b100;

  logic CLK, nRST;
  mem_xfer_sched_if bus();

  mem_xfer_sched dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  vec_t vecs [30];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] sp,
                                     input logic [2:0] w, input logic [15:0] imm);
    return {op, w, sp, 5'd0, imm};
  endfunction

  function automatic logic [23:0] dv(input logic we, input logic [2:0] sp, input logic [2:0] w,
                                     input logic [15:0] a, input logic last);
    return {we, sp, w, a, last};
  endfunction

  function automatic vec_t v(input logic iv, input logic [31:0] ins, input logic [3:0] ctrl,
                             input logic [23:0] data);
    vec_t r;
    r.iv = iv; r.ins = ins; r.ctrl = ctrl; r.data = data;
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rst_view();
    return {4'd0, bus.mem_req_valid, bus.instr_ready, bus.mem_req_we, bus.mem_req_buf,
            bus.mem_req_width, bus.mem_req_addr, bus.mem_req_last, bus.blk_done, bus.instr_err};
  endfunction

  initial begin
    logic [31:0] act, exp;
    logic [15:0] ea;
    logic        rb, ivs, hn, got_full;
    int          acc, hs;

    vecs[0]  = v(1'b1, mk(SETUP,  SP_I, 3'd0, 16'h0100), C_IDLE, 24'd0);
    vecs[1]  = v(1'b1, mk(LD_MEM, SP_I, 3'd2, 16'd3),    C_IDLE, 24'd0);
    vecs[2]  = v(1'b0, 32'd0, C_ISS,  dv(1'b0, SP_I, 3'd2, 16'h0100, 1'b0));
    vecs[3]  = v(1'b0, 32'd0, C_ISS,  dv(1'b0, SP_I, 3'd2, 16'h0101, 1'b0));
    vecs[4]  = v(1'b0, 32'd0, C_ISS,  dv(1'b0, SP_I, 3'd2, 16'h0102, 1'b1));
    vecs[5]  = v(1'b0, 32'd0, C_IDLE, 24'd0);
    vecs[6]  = v(1'b1, mk(LD_MEM, SP_I, 3'd2, 16'd1),    C_IDLE, 24'd0);
    vecs[7]  = v(1'b0, 32'd0, C_ISS,  dv(1'b0, SP_I, 3'd2, 16'h0103, 1'b1));
    vecs[8]  = v(1'b0, 32'd0, C_IDLE, 24'd0);
    vecs[9]  = v(1'b1, mk(ST_MEM, SP_O, 3'd5, 16'd2),    C_IDLE, 24'd0);
    vecs[10] = v(1'b1, mk(LD_MEM, SP_W, 3'd1, 16'd2),    C_ISS, dv(1'b1, SP_O, 3'd5, 16'h0000, 1'b0));
    vecs[11] = v(1'b0, 32'd0, C_ISS,  dv(1'b1, SP_O, 3'd5, 16'h0001, 1'b1));
    vecs[12] = v(1'b0, 32'd0, C_ISS,  dv(1'b0, SP_W, 3'd1, 16'h0000, 1'b0));
    vecs[13] = v(1'b0, 32'd0, C_ISS,  dv(1'b0, SP_W, 3'd1, 16'h0001, 1'b1));
    vecs[14] = v(1'b0, 32'd0, C_IDLE, 24'd0);
    vecs[15] = v(1'b1, mk(SETUP,  SP_W, 3'd0, 16'hFFFE), C_IDLE, 24'd0);
    vecs[16] = v(1'b1, mk(LD_MEM, SP_W, 3'd7, 16'd4),    C_IDLE, 24'd0);
    vecs[17] = v(1'b0, 32'd0, C_ISS,  dv(1'b0, SP_W, 3'd7, 16'hFFFE, 1'b0));
    vecs[18] = v(1'b0, 32'd0, C_ISS,  dv(1'b0, SP_W, 3'd7, 16'hFFFF, 1'b0));
    vecs[19] = v(1'b0, 32'd0, C_ISS,  dv(1'b0, SP_W, 3'd7, 16'h0000, 1'b0));
    vecs[20] = v(1'b0, 32'd0, C_ISS,  dv(1'b0, SP_W, 3'd7, 16'h0001, 1'b1));
    vecs[21] = v(1'b0, 32'd0, C_IDLE, 24'd0);
    vecs[22] = v(1'b1, mk(LD_MEM, 3'b011, 3'd0, 16'd2),  C_ERR,  24'd0);
    vecs[23] = v(1'b1, mk(LD_MEM, SP_I, 3'd0, 16'd0),    C_IDLE, 24'd0);
    vecs[24] = v(1'b0, 32'd0, C_IDLE, 24'd0);
    vecs[25] = v(1'b1, mk(LD_MEM, SP_I, 3'd3, 16'd1),    C_IDLE, 24'd0);
    vecs[26] = v(1'b0, 32'd0, C_ISS,  dv(1'b0, SP_I, 3'd3, 16'h0104, 1'b1));
    vecs[27] = v(1'b0, 32'd0, C_IDLE, 24'd0);
    vecs[28] = v(1'b1, mk(COMPUTE, 3'b011, 3'd0, 16'd9), C_IDLE, 24'd0);
    vecs[29] = v(1'b1, mk(RD_BUF,  SP_I,   3'd0, 16'd4), C_IDLE, 24'd0);

    // Reset
    nRST = 1'b0;
    bus.instr_valid   = 1'b0;
    bus.instr         = 32'd0;
    bus.mem_req_ready = 1'b1;
    step();
    step();
    chk("reset", rst_view(), {4'd0, 1'b0, 1'b1, 26'd0});
    nRST = 1'b1;

    // Table-driven vectors, memory always ready
    for (int i = 0; i < 30; i++) begin
      bus.instr_valid = vecs[i].iv;
      bus.instr       = vecs[i].ins;
      step();
      act = {4'd0, bus.mem_req_valid, bus.instr_ready, bus.instr_err, bus.blk_done, 24'd0};
      exp = {4'd0, vecs[i].ctrl, 24'd0};
      if (vecs[i].ctrl[3]) begin
        act[23:0] = {bus.mem_req_we, bus.mem_req_buf, bus.mem_req_width,
                     bus.mem_req_addr, bus.mem_req_last};
        exp[23:0] = vecs[i].data;
      end
      chk($sformatf("vec%0d", i), act, exp);
    end
    bus.instr_valid = 1'b0;

    // Backpressure: 11 one-word LDs fill 10 table slots plus the working registers
    bus.mem_req_ready = 1'b0;
    acc = 0;
    got_full = 1'b0;
    for (int c = 0; c < 40; c++) begin
      rb  = bus.instr_ready;
      ivs = (acc < 11);
      bus.instr_valid = ivs;
      bus.instr       = mk(LD_MEM, SP_I, 3'd0, 16'd1);
      step();
      if (ivs && rb) acc++;
      if (!bus.instr_ready) begin
        got_full = 1'b1;
        break;
      end
    end
    bus.instr_valid = 1'b0;
    chk("bp_full", {31'd0, got_full}, 32'd1);
    chk("bp_accepted", acc, 32'd11);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_hold", {12'd0, bus.mem_req_valid, bus.instr_ready, bus.mem_req_last, bus.mem_req_addr},
          {12'd0, 1'b1, 1'b0, 1'b1, 16'h0105});
    end
    for (int i = 0; i < 11; i++) begin
      ea = 16'h0105 + 16'(i);
      chk("bp_drain", {13'd0, bus.mem_req_valid, bus.mem_req_we, bus.mem_req_last, bus.mem_req_addr},
          {13'd0, 1'b1, 1'b0, 1'b1, ea});
      bus.mem_req_ready = 1'b1;
      step();
    end
    chk("bp_empty", {30'd0, bus.mem_req_valid, bus.instr_ready}, {30'd0, 1'b0, 1'b1});

    // BLK_END behind a 5-word LD holds off the next instruction until drained
    bus.instr_valid = 1'b1;
    bus.instr = mk(LD_MEM, SP_I, 3'd0, 16'd5);
    step();
    bus.instr = mk(BLK_END, 3'b000, 3'd0, 16'd0);
    step();
    chk("blk_first", {14'd0, bus.mem_req_valid, bus.instr_ready, bus.mem_req_addr},
        {14'd0, 1'b1, 1'b0, 16'h0110});
    bus.instr = mk(SETUP, SP_O, 3'd0, 16'h0200);
    hs = 0;
    for (int c = 0; c < 20 && hs < 5; c++) begin
      hn = bus.mem_req_valid && bus.mem_req_ready;
      chk("blk_ready_low", {31'd0, bus.instr_ready}, 32'd0);
      step();
      if (hn) hs++;
    end
    chk("blk_hs", hs, 32'd5);
    chk("blk_after_last", {29'd0, bus.mem_req_valid, bus.blk_done, bus.instr_ready}, 32'd0);
    step();
    chk("blk_done_pulse", {30'd0, bus.blk_done, bus.instr_ready}, {30'd0, 1'b1, 1'b1});
    step();
    bus.instr_valid = 1'b0;
    chk("blk_done_clear", {31'd0, bus.blk_done}, 32'd0);
    bus.instr_valid = 1'b1;
    bus.instr = mk(LD_MEM, SP_O, 3'd0, 16'd1);
    step();
    bus.instr_valid = 1'b0;
    step();
    chk("setup_after_blk", {12'd0, bus.mem_req_valid, bus.mem_req_buf, bus.mem_req_addr},
        {12'd0, 1'b1, SP_O, 16'h0200});
    step();

    // BLK_END with nothing outstanding
    bus.instr_valid = 1'b1;
    bus.instr = mk(BLK_END, 3'b000, 3'd0, 16'd0);
    step();
    bus.instr_valid = 1'b0;
    chk("blk_idle_accept", {30'd0, bus.instr_ready, bus.blk_done}, 32'd0);
    step();
    chk("blk_idle_done", {30'd0, bus.instr_ready, bus.blk_done}, {30'd0, 1'b1, 1'b1});
    step();
    chk("blk_idle_clear", {31'd0, bus.blk_done}, 32'd0);

    // Reset in the middle of a transfer
    bus.instr_valid = 1'b1;
    bus.instr = mk(LD_MEM, SP_I, 3'd0, 16'd4);
    step();
    bus.instr_valid = 1'b0;
    step();
    chk("rst_pre", {15'd0, bus.mem_req_valid, bus.mem_req_addr}, {15'd0, 1'b1, 16'h0115});
    step();
    nRST = 1'b0;
    step();
    chk("rst_mid", rst_view(), {4'd0, 1'b0, 1'b1, 26'd0});
    nRST = 1'b1;
    step();
    step();
    chk("rst_discard", {31'd0, bus.mem_req_valid}, 32'd0);
    bus.instr_valid = 1'b1;
    bus.instr = mk(LD_MEM, SP_I, 3'd0, 16'd1);
    step();
    bus.instr_valid = 1'b0;
    step();
    chk("rst_ptr", {15'd0, bus.mem_req_valid, bus.mem_req_addr}, {15'd0, 1'b1, 16'h0000});
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
